// File: rtl/vdp99_vga_out.sv
// vdp99_vga_out: TMS9918 palette lookup, sync re-timing and visible-window gating for the VGA DAC.
// Optional build macro VDP99_SCANLINE_EN halves every visible channel on odd lines.
`timescale 1ns/1ps
module vdp99_vga_out #(
    parameter bit SYNC_ACTIVE    = 1'b0,
    parameter int H_ACTIVE_START = 144,
    parameter int H_ACTIVE_LEN   = 640,
    parameter int V_ACTIVE_START = 35,
    parameter int V_ACTIVE_LEN   = 480,
    parameter int HCW            = 11,
    parameter int VCW            = 10
) (
    input  logic       pxclk,
    input  logic       reset,
    input  logic [3:0] color,
    input  logic       hsync,
    input  logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de
);

    localparam logic [HCW-1:0] H_LO = HCW'(H_ACTIVE_START);
    localparam logic [HCW-1:0] H_HI = HCW'(H_ACTIVE_START + H_ACTIVE_LEN);
    localparam logic [VCW-1:0] V_LO = VCW'(V_ACTIVE_START);
    localparam logic [VCW-1:0] V_HI = VCW'(V_ACTIVE_START + V_ACTIVE_LEN);

    // The saturated count must lie outside the window so an unsynchronised counter keeps de low.
    if (H_ACTIVE_START + H_ACTIVE_LEN > (2 ** HCW) - 1) begin : g_h_range_err
        $error("vdp99_vga_out: horizontal window does not fit in HCW bits");
    end
    if (V_ACTIVE_START + V_ACTIVE_LEN > (2 ** VCW) - 1) begin : g_v_range_err
        $error("vdp99_vga_out: vertical window does not fit in VCW bits");
    end

    function automatic logic [HCW-1:0] h_sat_inc(input logic [HCW-1:0] c);
        return (c == '1) ? c : c + HCW'(1);
    endfunction

    function automatic logic [VCW-1:0] v_sat_inc(input logic [VCW-1:0] c);
        return (c == '1) ? c : c + VCW'(1);
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] idx);
        logic [11:0] rgb;
        case (idx)
            4'h0:    rgb = 12'h000;
            4'h1:    rgb = 12'h000;
            4'h2:    rgb = 12'h2C4;
            4'h3:    rgb = 12'h5D7;
            4'h4:    rgb = 12'h55E;
            4'h5:    rgb = 12'h77F;
            4'h6:    rgb = 12'hD54;
            4'h7:    rgb = 12'h4EF;
            4'h8:    rgb = 12'hF55;
            4'h9:    rgb = 12'hF77;
            4'hA:    rgb = 12'hDC5;
            4'hB:    rgb = 12'hEC8;
            4'hC:    rgb = 12'h2B3;
            4'hD:    rgb = 12'hC5B;
            4'hE:    rgb = 12'hCCC;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

`ifdef VDP99_SCANLINE_EN
    function automatic logic [11:0] dim(input logic [11:0] rgb);
        return {1'b0, rgb[11:9], 1'b0, rgb[7:5], 1'b0, rgb[3:1]};
    endfunction
`endif

    // Stage 1: capture inputs, track position relative to the last sync leading edges
    logic [3:0]     color_p1;
    logic           hs_p1;
    logic           vs_p1;
    logic [HCW-1:0] hcount_p1;
    logic [VCW-1:0] vcount_p1;
    logic           hs_lead;
    logic           vs_lead;

    assign hs_lead = (hsync == SYNC_ACTIVE) && (hs_p1 != SYNC_ACTIVE);
    assign vs_lead = (vsync == SYNC_ACTIVE) && (vs_p1 != SYNC_ACTIVE);

    always_ff @(posedge pxclk) begin
        color_p1 <= color;
    end

    always_ff @(posedge pxclk) begin
        if (!reset) begin
            hs_p1     <= ~SYNC_ACTIVE;
            vs_p1     <= ~SYNC_ACTIVE;
            hcount_p1 <= '1;
            vcount_p1 <= '1;
        end else begin
            hs_p1     <= hsync;
            vs_p1     <= vsync;
            hcount_p1 <= hs_lead ? '0 : h_sat_inc(hcount_p1);
            if (vs_lead) begin
                vcount_p1 <= '0;
            end else if (hs_lead) begin
                vcount_p1 <= v_sat_inc(vcount_p1);
            end
        end
    end

    // Stage 2: window decode, palette lookup and output registers
    logic        vis_p1;
    logic [11:0] rgb_nx;
    logic [11:0] rgb_p2;

    assign vis_p1 = (hcount_p1 >= H_LO) && (hcount_p1 < H_HI) &&
                    (vcount_p1 >= V_LO) && (vcount_p1 < V_HI);

    always_comb begin
        rgb_nx = vis_p1 ? pal(color_p1) : 12'h000;
`ifdef VDP99_SCANLINE_EN
        if (vcount_p1[0]) begin
            rgb_nx = dim(rgb_nx);
        end
`endif
    end

    always_ff @(posedge pxclk) begin
        if (!reset) begin
            rgb_p2  <= 12'h000;
            de      <= 1'b0;
            hsync_o <= ~SYNC_ACTIVE;
            vsync_o <= ~SYNC_ACTIVE;
        end else begin
            rgb_p2  <= rgb_nx;
            de      <= vis_p1;
            hsync_o <= hs_p1;
            vsync_o <= vs_p1;
        end
    end

    assign red   = rgb_p2[11:8];
    assign green = rgb_p2[7:4];
    assign blue  = rgb_p2[3:0];

endmodule

// File: tb/tb_vdp99_vga_out.sv
// Self-checking bench for vdp99_vga_out: a frame-position model predicts every output cycle,
// with literal expectations at window edges, palette points, sync alignment and reset.
`timescale 1ns/1ps
module tb_vdp99_vga_out;

    localparam bit SA = 1'b0;

    logic       pxclk = 1'b0;
    logic       reset;
    logic [3:0] color;
    logic       hsync;
    logic       vsync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hsync_o;
    logic       vsync_o;
    logic       de;

    int checks = 0;
    int errors = 0;
    int shown  = 0;

    always #20 pxclk = ~pxclk;

    vdp99_vga_out dut (
        .pxclk   (pxclk),
        .reset   (reset),
        .color   (color),
        .hsync   (hsync),
        .vsync   (vsync),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .de      (de)
    );

    logic [11:0] pal_ref [16] = '{12'h000, 12'h000, 12'h2C4, 12'h5D7, 12'h55E, 12'h77F,
                                  12'hD54, 12'h4EF, 12'hF55, 12'hF77, 12'hDC5, 12'hEC8,
                                  12'h2B3, 12'hC5B, 12'hCCC, 12'hFFF};

    localparam logic [14:0] IDLE = {1'b0, 12'h000, ~SA, ~SA};

    // Model: pixel/line position since the last sync leading edges; -1 means not yet known.
    logic [14:0] exp_now;
    logic [14:0] exp_pend;
    bit          model_live = 1'b0;
    int          mh;
    int          mv;
    logic        prev_hs;
    logic        prev_vs;
    logic        hle;
    logic        vle;
    logic        vis;
    logic [11:0] px;

    initial forever begin
        @(posedge pxclk);
        if (!reset) begin
            exp_now    = IDLE;
            exp_pend   = IDLE;
            mh         = -1;
            mv         = -1;
            prev_hs    = ~SA;
            prev_vs    = ~SA;
            model_live = 1'b1;
        end else begin
            hle = (hsync == SA) && (prev_hs != SA);
            vle = (vsync == SA) && (prev_vs != SA);
            if (hle) mh = 0;
            else if (mh >= 0) mh++;
            if (vle) mv = 0;
            else if (hle && mv >= 0) mv++;
            vis = (mh >= 144) && (mh < 144 + 640) && (mv >= 35) && (mv < 35 + 480);
            px  = vis ? pal_ref[color] : 12'h000;
`ifdef VDP99_SCANLINE_EN
            if (vis && (mv % 2 == 1)) px = {px[11:8] >> 1, px[7:4] >> 1, px[3:0] >> 1};
`endif
            exp_now  = exp_pend;
            exp_pend = {vis, px, hsync, vsync};
            prev_hs  = hsync;
            prev_vs  = vsync;
        end
    end

    initial forever begin
        @(negedge pxclk);
        if (model_live) begin
            checks++;
            if ({de, red, green, blue, hsync_o, vsync_o} !== exp_now) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL cycle_model t=%0t got de/rgb/hs/vs=%h want %h", $time,
                             {de, red, green, blue, hsync_o, vsync_o}, exp_now);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] c, input logic h, input logic v);
        reset = r;
        color = c;
        hsync = h;
        vsync = v;
        @(negedge pxclk);
    endtask

    // One 800-clock line; hsync pulse on clocks 0..95. Outputs after step j belong to sample j-1.
    task automatic run_line(input bit with_vs, input int mode, input int ln, input int rst_at);
        logic [3:0]  c;
        logic        r;
        logic [11:0] want;
        int          p;
        int          k;
        for (int j = 0; j < 800; j++) begin
            r = !(rst_at >= 0 && j >= rst_at && j < rst_at + 3);
            case (mode)
                1:       c = (j >= 144 && j < 784) ? 4'((j - 144) / 40) : 4'hA;
                2, 3:    c = 4'hF;
                4:       c = 4'(j);
                default: c = 4'h3;
            endcase
            step(r, c, (j < 96) ? SA : ~SA, with_vs ? SA : ~SA);
            p = j - 1;
            if (with_vs && ln == 0 && j == 0)
                chk("sync_not_early", {hsync_o, vsync_o}, {~SA, ~SA});
            if (with_vs && ln == 0 && j == 1)
                chk("sync_two_clk", {hsync_o, vsync_o}, {SA, SA});
            if (mode == 0 && (rst_at < 0 || p < rst_at)) begin
                if (p == 144 || p == 783)
                    chk("window_in", {de, red, green, blue}, {1'b1, 12'h5D7});
                if (p == 143 || p == 784)
                    chk("window_out", {de, red, green, blue}, {1'b0, 12'h000});
            end
            if (rst_at >= 0 && j == rst_at - 1)
                chk("pre_reset", {de, red, green, blue}, {1'b1, 12'h5D7});
            if (rst_at >= 0 && j == rst_at)
                chk("mid_reset", {de, red, green, blue, hsync_o, vsync_o}, IDLE);
            if (mode == 1 && p >= 144 && p < 784 && ((p - 144) % 40) == 20) begin
                k = (p - 144) / 40;
                case (k)
                    0:  chk("pal_idx0", {de, red, green, blue}, {1'b1, 12'h000});
                    2:  chk("pal_idx2", {de, red, green, blue}, {1'b1, 12'h2C4});
                    10: chk("pal_idxA", {de, red, green, blue}, {1'b1, 12'hDC5});
                    15: chk("pal_idxF", {de, red, green, blue}, {1'b1, 12'hFFF});
                    default: ;
                endcase
            end
            if (mode == 2)
                chk("dark_after_reset", de, 0);
            if (mode == 3 && p == 200) begin
                want = 12'hFFF;
`ifdef VDP99_SCANLINE_EN
                if (ln % 2 == 1) want = 12'h777;
`endif
                chk("scanline", {red, green, blue}, want);
            end
        end
    endtask

    initial begin
        int mode;
        for (int i = 0; i < 4; i++) step(1'b0, 4'hF, ~SA, ~SA);
        chk("reset_out", {de, red, green, blue, hsync_o, vsync_o}, IDLE);

        for (int i = 0; i < 3000; i++) begin
            step(1'b1, 4'h3, ~SA, ~SA);
            chk("idle_de", de, 0);
        end

        for (int ln = 0; ln < 40; ln++) begin
            if (ln == 35 || ln == 39)      mode = 0;
            else if (ln == 36 || ln == 37) mode = 3;
            else if (ln == 38)             mode = 1;
            else                           mode = 4;
            run_line(ln < 2, mode, ln, (ln == 39) ? 300 : -1);
        end

        for (int ln = 0; ln < 4; ln++) run_line(1'b0, 2, -1, -1);

        for (int ln = 0; ln < 36; ln++) run_line(ln < 2, (ln == 35) ? 0 : 4, ln, -1);

        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, ~SA, ~SA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
